// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the operand fetch stage: opcodes,
// register-usage decode and the output-register state encoding.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } reg_use_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  function automatic reg_use_t decode_reg_use(input logic [6:0] opc);
    reg_use_t u;
    u = '0;
    case (opc)
      OPC_OP: begin
        u.uses_rs1  = 1'b1;
        u.uses_rs2  = 1'b1;
        u.writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        u.uses_rs1  = 1'b1;
        u.writes_rd = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        u.uses_rs1 = 1'b1;
        u.uses_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: u.writes_rd = 1'b1;
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundle of the IF/ID input, register-file read, writeback retire, flush and
// ID/EX output signals of the operand fetch stage.
interface operand_fetch_stage_if #(parameter int XLEN = riscv_pkg::XLEN_DEF);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      rf_rs1;
  logic [4:0]      rf_rs2;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [4:0]      out_rd;
  logic            out_writes_rd;

  // Stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, rf_rd1, rf_rd2, wb_valid, wb_rd, flush, out_ready,
    output in_ready, rf_rs1, rf_rs2, out_valid, out_instr, out_pc, out_rs1_val,
           out_rs2_val, out_rd, out_writes_rd
  );

  // Surrounding pipeline side.
  modport master (
    output in_valid, in_instr, in_pc, rf_rd1, rf_rd2, wb_valid, wb_rd, flush, out_ready,
    input  in_ready, rf_rs1, rf_rs2, out_valid, out_instr, out_pc, out_rs1_val,
           out_rs2_val, out_rd, out_writes_rd
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: one set port, two clear ports (retire, flush kill),
// set wins on a shared index; x0 is never busy.
module reg_scoreboard #(
  parameter int NREG = riscv_pkg::NREG_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_set_en,
  input  logic [4:0] i_set_idx,
  input  logic       i_clr_a_en,
  input  logic [4:0] i_clr_a_idx,
  input  logic       i_clr_b_en,
  input  logic [4:0] i_clr_b_idx,
  input  logic [4:0] i_q1_idx,
  input  logic [4:0] i_q2_idx,
  input  logic [4:0] i_q3_idx,
  output logic       o_q1_busy,
  output logic       o_q2_busy,
  output logic       o_q3_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_a_en) w_busy_nxt[i_clr_a_idx] = 1'b0;
    if (i_clr_b_en) w_busy_nxt[i_clr_b_idx] = 1'b0;
    if (i_set_en)   w_busy_nxt[i_set_idx]   = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Lookups see registered state only; a retire this cycle does not unblock yet.
  assign o_q1_busy = r_busy[i_q1_idx];
  assign o_q2_busy = r_busy[i_q2_idx];
  assign o_q3_busy = r_busy[i_q3_idx];

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-side register file reader: interlocks RAW/WAW hazards through the
// busy scoreboard and captures operands into the ID/EX output register.
module operand_fetch_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_fetch_stage_if.slave bus
);

  reg_use_t   w_use;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;
  logic       w_rs1_busy;
  logic       w_rs2_busy;
  logic       w_rd_busy;
  logic       w_hazard;
  logic       w_in_ready;
  logic       w_issue;
  logic       w_set_en;
  logic       w_kill_clr;

  out_state_t      r_state_p1;
  logic [31:0]     r_instr_p1;
  logic [XLEN-1:0] r_pc_p1;
  logic [XLEN-1:0] r_rs1_val_p1;
  logic [XLEN-1:0] r_rs2_val_p1;
  logic [4:0]      r_rd_p1;
  logic            r_writes_rd_p1;

  assign w_use = decode_reg_use(bus.in_instr[6:0]);
  assign w_rs1 = bus.in_instr[19:15];
  assign w_rs2 = bus.in_instr[24:20];
  assign w_rd  = bus.in_instr[11:7];

  assign bus.rf_rs1 = w_rs1;
  assign bus.rf_rs2 = w_rs2;

  assign w_hazard = (w_use.uses_rs1  && (w_rs1 != 5'd0) && w_rs1_busy) ||
                    (w_use.uses_rs2  && (w_rs2 != 5'd0) && w_rs2_busy) ||
                    (w_use.writes_rd && (w_rd  != 5'd0) && w_rd_busy);

  assign w_in_ready = !bus.flush && !w_hazard &&
                      ((r_state_p1 == OUT_EMPTY) || bus.out_ready);
  assign w_issue    = bus.in_valid && w_in_ready;
  assign w_set_en   = w_issue && w_use.writes_rd && (w_rd != 5'd0);

  // A flushed instruction never reaches writeback, so its busy bit is released
  // here; if EX took it in the same cycle, writeback still owes the retire.
  assign w_kill_clr = bus.flush && (r_state_p1 == OUT_FULL) && !bus.out_ready &&
                      r_writes_rd_p1;

  reg_scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_set_en),
    .i_set_idx  (w_rd),
    .i_clr_a_en (bus.wb_valid),
    .i_clr_a_idx(bus.wb_rd),
    .i_clr_b_en (w_kill_clr),
    .i_clr_b_idx(r_rd_p1),
    .i_q1_idx   (w_rs1),
    .i_q2_idx   (w_rs2),
    .i_q3_idx   (w_rd),
    .o_q1_busy  (w_rs1_busy),
    .o_q2_busy  (w_rs2_busy),
    .o_q3_busy  (w_rd_busy)
  );

  // ---- ID/EX boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_p1     <= OUT_EMPTY;
      r_instr_p1     <= '0;
      r_pc_p1        <= '0;
      r_rs1_val_p1   <= '0;
      r_rs2_val_p1   <= '0;
      r_rd_p1        <= '0;
      r_writes_rd_p1 <= 1'b0;
    end else begin
      case (r_state_p1)
        OUT_EMPTY: if (w_issue) r_state_p1 <= OUT_FULL;
        OUT_FULL: begin
          if (bus.flush)                       r_state_p1 <= OUT_EMPTY;
          else if (bus.out_ready && !w_issue)  r_state_p1 <= OUT_EMPTY;
        end
        default: r_state_p1 <= OUT_EMPTY;
      endcase
      if (w_issue) begin
        r_instr_p1     <= bus.in_instr;
        r_pc_p1        <= bus.in_pc;
        r_rs1_val_p1   <= bus.rf_rd1;
        r_rs2_val_p1   <= bus.rf_rd2;
        r_rd_p1        <= w_rd;
        r_writes_rd_p1 <= w_use.writes_rd && (w_rd != 5'd0);
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = (r_state_p1 == OUT_FULL);
  assign bus.out_instr     = r_instr_p1;
  assign bus.out_pc        = r_pc_p1;
  assign bus.out_rs1_val   = r_rs1_val_p1;
  assign bus.out_rs2_val   = r_rs2_val_p1;
  assign bus.out_rd        = r_rd_p1;
  assign bus.out_writes_rd = r_writes_rd_p1;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: queue of expected ID/EX contents
// plus direct checks of handshake and busy-bit behaviour.
module tb_operand_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_fetch_stage_if #(.XLEN(32)) bus ();

  operand_fetch_stage #(.XLEN(32), .NREG(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] rf [32];
  assign bus.rf_rd1 = rf[bus.rf_rs1];
  assign bus.rf_rd2 = rf[bus.rf_rs2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  rd;
    logic        wr;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  logic [31:0] pc;
  logic [31:0] a_pc;
  logic [31:0] ins_a, ins_b, ins_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // Independent writes-rd model: table of register-writing opcodes.
  function automatic logic exp_wr(input logic [31:0] ins);
    case (ins[6:0])
      7'h33, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h6F: return ins[11:7] != 5'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] busy_bit(input int idx);
    return {31'b0, dut.u_sb.r_busy[idx]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins);
    bus.in_instr = ins;
    bus.in_pc    = pc;
    pc           = pc + 32'd4;
    bus.in_valid = 1'b1;
  endtask

  task automatic retire(input logic [4:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = r;
    cyc();
    bus.wb_valid = 1'b0;
  endtask

  // Scoreboard: consume on output handshake, record on issue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.flush && !bus.out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("sb_underflow", 32'(q.size()), 32'd1);
        else begin
          m_e = q.pop_front();
          chk("sb_instr", bus.out_instr, m_e.instr);
          chk("sb_pc", bus.out_pc, m_e.pc);
          chk("sb_rs1", bus.out_rs1_val, m_e.v1);
          chk("sb_rs2", bus.out_rs2_val, m_e.v2);
          chk("sb_rd", {27'b0, bus.out_rd}, {27'b0, m_e.rd});
          chk("sb_wr", {31'b0, bus.out_writes_rd}, {31'b0, m_e.wr});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{instr: bus.in_instr, pc: bus.in_pc,
                      v1: rf[bus.in_instr[19:15]], v2: rf[bus.in_instr[24:20]],
                      rd: bus.in_instr[11:7], wr: exp_wr(bus.in_instr)});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {16'hA5A5, 16'(i)};
    rf[0]         = 32'd0;
    pc            = 32'h100;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(32'h0000_0013);
    #3;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_busy", dut.u_sb.r_busy, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_rs1", bus.out_rs1_val, 32'd0);
    chk("rst_out_rs2", bus.out_rs2_val, 32'd0);
    chk("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
    chk("rst_out_wr", {31'b0, bus.out_writes_rd}, 32'd0);
    cyc();
    cyc();
    chk("rst_hold_valid", {31'b0, bus.out_valid}, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("issue_latency", {31'b0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    cyc();
    chk("drain_nop", {31'b0, bus.out_valid}, 32'd0);

    // RAW: add x3,x1,x2 then sub x4,x3,x1
    drive(mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33));
    cyc();
    chk("raw_busy3_set", busy_bit(3), 32'd1);
    drive(mk(7'h20, 5'd1, 5'd3, 3'd0, 5'd4, 7'h33));
    #1;
    chk("raw_stall", {31'b0, bus.in_ready}, 32'd0);
    chk("rf_rs1_addr", {27'b0, bus.rf_rs1}, 32'd3);
    chk("rf_rs2_addr", {27'b0, bus.rf_rs2}, 32'd1);
    cyc();
    cyc();
    chk("raw_stall_hold", {31'b0, bus.in_ready}, 32'd0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    #1;
    chk("raw_no_wb_bypass", {31'b0, bus.in_ready}, 32'd0);
    cyc();
    bus.wb_valid = 1'b0;
    rf[3]        = 32'hCAFE_0003;
    #1;
    chk("raw_release", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    chk("raw_sub_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("raw_sub_rs1", bus.out_rs1_val, 32'hCAFE_0003);
    chk("raw_busy3_clr", busy_bit(3), 32'd0);
    chk("raw_busy4_set", busy_bit(4), 32'd1);
    bus.in_valid = 1'b0;
    cyc();
    retire(5'd4);

    // x0 writes and reads
    drive(mk(7'h00, 5'd1, 5'd0, 3'd0, 5'd0, 7'h13));
    cyc();
    chk("x0_no_write", {31'b0, bus.out_writes_rd}, 32'd0);
    chk("x0_busy_zero", dut.u_sb.r_busy, 32'd0);
    drive(mk(7'h00, 5'd0, 5'd0, 3'd0, 5'd5, 7'h33));
    #1;
    chk("x0_no_stall", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    chk("x0_busy5", busy_bit(5), 32'd1);
    chk("x0_rs1_zero", bus.out_rs1_val, 32'd0);
    bus.in_valid = 1'b0;
    cyc();
    retire(5'd5);

    // Backpressure
    bus.out_ready = 1'b0;
    ins_a = mk(7'h00, 5'h11, 5'd0, 3'd0, 5'd11, 7'h13);
    ins_b = mk(7'h00, 5'h12, 5'd0, 3'd0, 5'd12, 7'h13);
    ins_c = mk(7'h00, 5'h13, 5'd0, 3'd0, 5'd13, 7'h13);
    a_pc  = pc;
    drive(ins_a);
    cyc();
    drive(ins_b);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_instr", bus.out_instr, ins_a);
      chk("bp_pc", bus.out_pc, a_pc);
      chk("bp_rs1", bus.out_rs1_val, 32'd0);
      chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    chk("bp_b_loaded", bus.out_instr, ins_b);
    drive(ins_c);
    cyc();
    chk("bp_c_loaded", bus.out_instr, ins_c);
    bus.in_valid = 1'b0;
    cyc();
    chk("bp_drained", {31'b0, bus.out_valid}, 32'd0);
    retire(5'd11);
    retire(5'd12);
    retire(5'd13);
    chk("bp_busy_clear", dut.u_sb.r_busy, 32'd0);

    // Flush of held lui x7
    bus.out_ready = 1'b0;
    drive(mk(7'h00, 5'd0, 5'd0, 3'd1, 5'd7, 7'h37));
    cyc();
    bus.in_valid = 1'b0;
    chk("fl_busy7_set", busy_bit(7), 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("fl_in_ready", {31'b0, bus.in_ready}, 32'd0);
    cyc();
    bus.flush = 1'b0;
    chk("fl_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("fl_busy7_clr", busy_bit(7), 32'd0);
    bus.out_ready = 1'b1;
    drive(mk(7'h00, 5'd1, 5'd7, 3'd0, 5'd8, 7'h13));
    #1;
    chk("fl_no_stall", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    chk("fl_addi_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("fl_busy8", busy_bit(8), 32'd1);
    bus.in_valid = 1'b0;
    cyc();
    retire(5'd8);

    // Retire x3 while issuing lui x6
    drive(mk(7'h00, 5'd5, 5'd0, 3'd0, 5'd3, 7'h13));
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("sim_busy3_pre", busy_bit(3), 32'd1);
    drive(mk(7'h00, 5'd0, 5'd0, 3'd2, 5'd6, 7'h37));
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    cyc();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b0;
    chk("sim_busy3", busy_bit(3), 32'd0);
    chk("sim_busy6", busy_bit(6), 32'd1);
    cyc();
    retire(5'd6);

    // sw x9,0(x10) with x9 busy
    drive(mk(7'h00, 5'd1, 5'd0, 3'd0, 5'd9, 7'h13));
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    drive(mk(7'h00, 5'd9, 5'd10, 3'd2, 5'd0, 7'h23));
    #1;
    chk("sw_stall", {31'b0, bus.in_ready}, 32'd0);
    cyc();
    chk("sw_stall_hold", {31'b0, bus.in_ready}, 32'd0);
    chk("sw_not_issued", {31'b0, bus.out_valid}, 32'd0);
    retire(5'd9);
    #1;
    chk("sw_release", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    chk("sw_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("sw_no_write", {31'b0, bus.out_writes_rd}, 32'd0);
    chk("sw_busy_none", dut.u_sb.r_busy, 32'd0);
    bus.in_valid = 1'b0;
    cyc();

    // jal x1 with x1 busy (WAW)
    drive(mk(7'h00, 5'd0, 5'd0, 3'd5, 5'd1, 7'h37));
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    drive(mk(7'h01, 5'd4, 5'd9, 3'd0, 5'd1, 7'h6F));
    #1;
    chk("waw_stall", {31'b0, bus.in_ready}, 32'd0);
    cyc();
    retire(5'd1);
    #1;
    chk("waw_release", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    chk("waw_busy1", busy_bit(1), 32'd1);
    chk("waw_wr", {31'b0, bus.out_writes_rd}, 32'd1);
    bus.in_valid = 1'b0;
    cyc();
    retire(5'd1);
    cyc();

    chk("end_busy_clear", dut.u_sb.r_busy, 32'd0);
    chk("end_queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

- Decode-side reader of the 32 x 32-bit register file in the 5-stage RV32I pipeline.
- Takes instructions from the IF/ID boundary and drives the register file read addresses. Captures the operand values into the ID/EX output register.
- Interlocks RAW/WAW hazards with a per-register busy scoreboard instead of forwarding.
- A pending write is cleared from the scoreboard only when writeback retires it.

## Interface
Parameters:
- XLEN, 32, data and PC width
- NREG, 32, architectural register count; x0 is always zero and never busy

Ports:
- clk  in  1  pipeline clock, all state updates on its rising edge
- rst_n  in  1  reset; asynchronous and active-low
- in_valid  in  1  IF/ID presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- rf_rs1  out  5  register file read address 1, equal to in_instr[19:15]
- rf_rs2  out  5  register file read address 2, equal to in_instr[24:20]
- rf_rd1  in  XLEN  combinational read data for rf_rs1
- rf_rd2  in  XLEN  combinational read data for rf_rs2
- wb_valid  in  1  retire pulse: one instruction issued by this stage has left writeback
- wb_rd  in  5  destination of the retiring instruction
- flush  in  1  kill the held output instruction and refuse input this cycle
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX consumes the held instruction
- out_instr  out  32  held instruction word
- out_pc  out  XLEN  held PC
- out_rs1_val  out  XLEN  captured rs1 operand
- out_rs2_val  out  XLEN  captured rs2 operand
- out_rd  out  5  held destination register
- out_writes_rd  out  1  held instruction writes rd (rd != 0)

## Operation
Register usage is decoded from opcode:
- OP (0110011): reads rs1 and rs2, writes rd.
- OP-IMM (0010011), LOAD (0000011), JALR (1100111): read rs1, write rd.
- STORE (0100011), BRANCH (1100011): read rs1 and rs2.
- LUI (0110111), AUIPC (0010111), JAL (1101111): write rd only.
- Any other opcode uses no registers and passes through.

Hazard detection:
- A hazard exists when any used source has a nonzero index whose busy bit is set.
- A hazard also exists when a written rd is nonzero and its busy bit is set (WAW).
- Busy bits are the registered scoreboard state only; there is no bypass from wb.
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`.

On issue (`in_valid && in_ready`):
- The output register loads instr, pc, rf_rd1, rf_rd2 and rd.
- `out_writes_rd` is 1 when the instruction writes rd and rd != 0.
- busy[rd] is set under the same condition.
- A source field that is not used is captured as read but ignored.

Output register:
- Two states. EMPTY goes to FULL on issue.
- FULL goes to EMPTY on `out_ready` with no issue.
- FULL stays FULL on `out_ready` with issue (back-to-back).
- FULL stays FULL and holds all outputs stable while `out_ready` is 0.

Retire: `wb_valid` clears busy[wb_rd] at the next edge. `wb_rd == 0` is a no-op.

Downstream obligation: every issued instruction that left this stage must produce exactly one wb_valid, even if killed downstream or its reg_write is 0.

Flush:
- out_valid goes to 0 at the next edge.
- If the held instruction has `out_writes_rd`, its busy bit is cleared, because it never reaches writeback.
- Busy bits of instructions already downstream are retained.

Simultaneous events:
- If set and clear hit the same index in one cycle, set wins.
- Retire and issue on different indices both apply.
- Flush together with `out_ready` treats the held instruction as consumed: its busy bit is kept.

## Timing
- Reset values: out_valid 0, all busy bits 0, out_instr, out_pc, out_rs1_val, out_rs2_val and out_rd 0, out_writes_rd 0.
- Reset mid-operation takes effect immediately and asynchronously.
- in_ready and rf_rs1/rf_rs2 are combinational from current inputs and state.
- Latency is 1 cycle from issue to out_valid.
- Throughput is 1 instruction per cycle when there is no hazard and out_ready is held high.
- A RAW stall ends in the cycle after the clearing wb_valid. By then the register file write is visible combinationally, so the dependent instruction issues in that cycle.

## Structure
- riscv_pkg holds:
  - opcode localparams
  - XLEN/NREG defaults
  - a `reg_use_t` struct {uses_rs1, uses_rs2, writes_rd}
  - a decode function opcode -> reg_use_t
- Sub-module reg_scoreboard:
  - NREG-bit busy vector with set and clear ports
  - set-wins priority
  - combinational busy lookup for three indices (rs1, rs2, rd)

## Test plan
- Reset with in_valid=1 and a NOP: out_valid=0 and in_ready=1 during reset. After release, issue with out_valid=1 one cycle later.
- `add x3,x1,x2` then `sub x4,x3,x1`: in_ready=0 until wb_valid with wb_rd=3. The sub issues the next cycle with out_rs1_val equal to the new x3 value.
- `addi x0,x0,1` then `add x5,x0,x0`: no stall, out_writes_rd=0 for the addi, and busy stays all-zero.
- out_ready=0 for 4 cycles with in_valid=1: outputs stay bit-stable and in_ready=0. After out_ready=1, one instruction drains per cycle.
- Held `lui x7,1` plus flush=1: out_valid=0 next cycle and busy[7] cleared. A following `addi x8,x7,1` issues with no stall.
- wb_valid with wb_rd=3 in the same cycle as issuing `lui x6,2`: after the edge, busy[3]=0 and busy[6]=1.
- `sw x9,0(x10)` with busy[9] set: stall.
- `jal x1,..` with busy[1] set: stall (WAW).
